// File: rtl/decode_inst_buffer.sv
// Decode-to-rename instruction buffer: compacts valid decode lanes into a circular FIFO and
// releases full rename bundles. Define INSTBUF_BYPASS_EN for a zero-latency empty-buffer bypass.
`timescale 1ns/1ps

`ifndef REN_PKT_SIZE
`define REN_PKT_SIZE 32
`endif

module decode_inst_buffer #(
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned PKT_W          = `REN_PKT_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic                            stall_i,
    input  logic                            decodeReady_i,
    input  logic [DISPATCH_WIDTH*PKT_W-1:0] decPacket_i,
    output logic                            stall_o,
    output logic [DISPATCH_WIDTH*PKT_W-1:0] renPacket_o,
    output logic                            instBufferReady_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PKT_W-1:0]          mem [DEPTH];
    logic [PtrW-1:0]           head_q, head_d;
    logic [PtrW-1:0]           tail_q, tail_d;
    logic [CntW-1:0]           count_q, count_d;

    logic [DISPATCH_WIDTH-1:0] lane_valid;
    logic [CntW-1:0]           nv;
    logic [PtrW-1:0]           lane_off [DISPATCH_WIDTH];
    logic                      buf_ready;
    logic                      bypass;
    logic                      wr;
    logic                      rd;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        nv = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            lane_valid[k] = decPacket_i[k*PKT_W];
            lane_off[k]   = nv[PtrW-1:0];
            if (lane_valid[k]) begin
                nv = nv + CntW'(1);
            end
        end
    end

    assign buf_ready = (count_q >= CntW'(DISPATCH_WIDTH));
    // Registered count only, so stall_i never reaches stall_o combinationally.
    assign stall_o   = (count_q > CntW'(DEPTH - DISPATCH_WIDTH));

`ifdef INSTBUF_BYPASS_EN
    assign bypass = (count_q == '0) & decodeReady_i & (&lane_valid) & ~stall_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign instBufferReady_o = (buf_ready | bypass) & ~flush_i;
    assign wr                = decodeReady_i & ~stall_o & ~flush_i & ~bypass;
    assign rd                = buf_ready & ~stall_i & ~flush_i;

    always_comb begin
        renPacket_o = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            renPacket_o[k*PKT_W +: PKT_W] = mem[head_q + PtrW'(k)];
        end
        if (bypass) begin
            renPacket_o = decPacket_i;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) begin
                tail_d = tail_q + nv[PtrW-1:0];
            end
            if (rd) begin
                head_d = head_q + PtrW'(DISPATCH_WIDTH);
            end
            count_d = count_q + (wr ? nv : '0) - (rd ? CntW'(DISPATCH_WIDTH) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale entries are masked by instBufferReady_o.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (lane_valid[k]) begin
                    mem[tail_q + lane_off[k]] <= decPacket_i[k*PKT_W +: PKT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_inst_buffer.sv
// Self-checking bench for decode_inst_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
`timescale 1ns/1ps

module tb_decode_inst_buffer;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 16;
    localparam int unsigned PW = 32;

`ifdef INSTBUF_BYPASS_EN
    localparam bit BypEn = 1'b1;
`else
    localparam bit BypEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            stall_i;
    logic            decodeReady_i;
    logic [W*PW-1:0] decPacket_i;
    logic            stall_o;
    logic [W*PW-1:0] renPacket_o;
    logic            instBufferReady_o;

    decode_inst_buffer #(
        .DISPATCH_WIDTH(W),
        .DEPTH         (D),
        .PKT_W         (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .decodeReady_i    (decodeReady_i),
        .decPacket_i      (decPacket_i),
        .stall_o          (stall_o),
        .renPacket_o      (renPacket_o),
        .instBufferReady_o(instBufferReady_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q[$];
    int          out_tags[$];
    bit          rec_en   = 1'b0;
    int          tag_ctr  = 0;
    int          tag_lim  = 32'h3fff_ffff;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Lane k is valid when mask[k]; valid lanes carry sequential tags in bits 31:1.
    task automatic mk(input logic [3:0] mask, output logic [127:0] pk);
        logic [31:0] junk;
        for (int k = 0; k < 4; k++) begin
            if (mask[k] && tag_ctr < tag_lim) begin
                pk[k*32 +: 32] = {tag_ctr[30:0], 1'b1};
                tag_ctr++;
            end else begin
                junk = $urandom();
                pk[k*32 +: 32] = {junk[31:1], 1'b0};
            end
        end
    endtask

    // Called at posedge+1: drive, check at negedge, then advance the model at the edge.
    task automatic step(input logic fl, input logic st, input logic dr, input logic [127:0] pk,
                        output logic acc);
        logic         exp_ready, exp_stall, byp, all_v;
        logic [127:0] exp_ren;
        int           sz;
        flush_i       = fl;
        stall_i       = st;
        decodeReady_i = dr;
        decPacket_i   = pk;
        #4;
        sz        = q.size();
        all_v     = pk[0] & pk[32] & pk[64] & pk[96];
        byp       = BypEn && sz == 0 && dr && all_v && !st && !fl;
        exp_stall = (D - sz) < W;
        exp_ready = !fl && (sz >= W || byp);
        check_eq("ready", instBufferReady_o, exp_ready);
        check_eq("stall_o", stall_o, exp_stall);
        if (exp_ready) begin
            exp_ren = byp ? pk : {q[3], q[2], q[1], q[0]};
            check_eq("ren", renPacket_o, exp_ren);
            if (rec_en && !st) begin
                for (int k = 0; k < 4; k++) out_tags.push_back(int'(renPacket_o[k*32+1 +: 31]));
            end
        end
        acc = dr && !exp_stall && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else if (!byp) begin
            if (exp_ready && !st) repeat (4) void'(q.pop_front());
            if (acc) begin
                for (int k = 0; k < 4; k++) if (pk[k*32]) q.push_back(pk[k*32 +: 32]);
            end
        end
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_ready", instBufferReady_o, 1'b0);
        check_eq("rst_stall", stall_o, 1'b0);
        q.delete();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] pk;
        logic         acc;
        logic [3:0]   m;
        bit           pending;

        reset         = 1'b1;
        flush_i       = 1'b0;
        stall_i       = 1'b0;
        decodeReady_i = 1'b0;
        decPacket_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_ready", instBufferReady_o, 1'b0);
        check_eq("init_stall", stall_o, 1'b0);
        reset = 1'b0;

        // Fill to 9 under stall, then reset mid-cycle.
        mk(4'b1111, pk); step(0, 1, 1, pk, acc);
        mk(4'b1111, pk); step(0, 1, 1, pk, acc);
        mk(4'b0001, pk); step(0, 1, 1, pk, acc);
        step(0, 1, 0, pk, acc);
        do_reset();

        // Compaction: lanes {1,3} then {0,1,2}.
        mk(4'b1010, pk); step(0, 1, 1, pk, acc);
        mk(4'b0111, pk); step(0, 1, 1, pk, acc);
        step(0, 1, 0, pk, acc);
        step(0, 0, 0, pk, acc);
        step(0, 0, 0, pk, acc);
        do_reset();

        // Fill to 16 under stall, hold a fifth bundle, release one bundle.
        for (int i = 0; i < 4; i++) begin
            mk(4'b1111, pk); step(0, 1, 1, pk, acc);
        end
        mk(4'b1111, pk);
        step(0, 1, 1, pk, acc);
        check_eq("held_full", acc, 1'b0);
        step(0, 0, 1, pk, acc);
        step(0, 1, 0, pk, acc);
        do_reset();

        // Flush at count 8 with simultaneous read and write.
        mk(4'b1111, pk); step(0, 1, 1, pk, acc);
        mk(4'b1111, pk); step(0, 1, 1, pk, acc);
        mk(4'b1111, pk); step(1, 0, 1, pk, acc);
        step(0, 0, 0, pk, acc);

        // Empty buffer, full bundle, no stall: bypass or one-cycle latency.
        mk(4'b1111, pk); step(0, 0, 1, pk, acc);
        step(0, 0, 0, pk, acc);
        step(0, 0, 0, pk, acc);
        do_reset();

        // 40 tagged packets through the pointer wrap with random stalls.
        tag_ctr = 0;
        tag_lim = 40;
        rec_en  = 1'b1;
        pending = 1'b0;
        for (int cyc = 0; cyc < 400 && out_tags.size() < 40; cyc++) begin
            if (!pending && tag_ctr < 40) begin
                m = 4'($urandom());
                mk(m, pk);
                pending = 1'b1;
            end
            step(0, ($urandom_range(0, 3) == 0), pending, pk, acc);
            if (acc) pending = 1'b0;
        end
        rec_en = 1'b0;
        check_eq("order_len", out_tags.size(), 40);
        for (int i = 0; i < out_tags.size() && i < 40; i++) check_eq("order", out_tags[i], i);
        tag_lim = 32'h3fff_ffff;
        do_reset();

        // Random traffic with occasional flush.
        pending = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                m = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom());
                mk(m, pk);
                pending = 1'b1;
            end
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0), pending, pk, acc);
            if (acc || flush_i) pending = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
